demux_1_4_buffered: RTL and testbench
=====================================

Name: demux_1_4_buffered

Overview:
- Stream demultiplexer: inverse of the 4:1 select path; routes one N-bit input stream to one of four output channels by a 2-bit select.
- Each output channel has its own DEPTH-entry FIFO and a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single producer (e.g. the writeback/result bus) and four independent consumers.

Parameters:
- N, 32, data width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  input word.
- in_sel  input  2  destination channel for in_data (0..3).
- in_valid  input  1  producer has a word.
- in_ready  output  1  selected channel can accept this cycle.
- out_0, out_1, out_2, out_3  output  N each  head-of-FIFO data for channels 0..3.
- out_valid  output  4  bit k set: channel k FIFO non-empty.
- out_ready  input  4  bit k set: consumer k takes the head word this cycle.

Behaviour:
- Per channel k: storage DEPTH x N, wr_ptr and rd_ptr of clog2(DEPTH) bits (natural wrap), count of clog2(DEPTH+1) bits.
- Combinational outputs:
  - full[k] = (count[k] == DEPTH); empty[k] = (count[k] == 0).
  - in_ready = !full[in_sel] && !rst. Depends on in_sel, not on in_valid.
  - out_valid[k] = !empty[k]; out_k = storage[k][rd_ptr[k]].
- Push:
  - Occurs when in_valid && in_ready.
  - Writes in_data to storage[in_sel][wr_ptr], increments wr_ptr and count of channel in_sel only.
- Pop:
  - Occurs when out_valid[k] && out_ready[k].
  - Increments rd_ptr[k] and decrements count[k]. All four channels may pop in the same cycle.
- Push and pop on the same channel in the same cycle:
  - count unchanged, both pointers advance.
  - Allowed only when not full. No pass-through when full: in_ready stays 0 even if the consumer pops that cycle.
- Latency: a word accepted at edge t appears on out_k with out_valid[k] = 1 immediately after edge t (one-cycle registered latency). No combinational path from in_data to out_k.
- Ordering:
  - Strict FIFO order within a channel.
  - No ordering guarantee between channels.
  - Head-of-line: if the selected channel is full, the producer stalls even when other channels have space.
- Pointer wrap: pointers wrap DEPTH-1 -> 0; count alone distinguishes full from empty.
- out_ready[k] while empty: ignored, no state change, count never underflows.
- in_valid with in_ready = 0: ignored; the producer must hold in_data/in_sel stable until accepted.
- Reset (rst high at an edge):
  - All counts and pointers go to 0 and all storage to 0.
  - After that edge, out_valid = 4'b0000, out_0..out_3 = 0 and in_ready = 1 (once rst is low).
  - While rst is high, in_ready = 0 and no push or pop takes effect.
  - Reset mid-stream discards all buffered words; no partial state survives.

Test Plan:
- Reset then idle: rst high 1 cycle, then low -> out_valid = 0000, out_0..3 = 0, in_ready = 1 for every in_sel.
- Single route: push 0xDEADBEEF with in_sel = 2 and all out_ready = 0 -> next cycle out_valid = 0100, out_2 = 0xDEADBEEF; pulse out_ready[2] -> out_valid = 0000.
- Fill and stall: with DEPTH = 2 and out_ready = 0, push 0x11 and 0x22 to channel 1 -> in_ready = 0 while in_sel = 1, in_ready = 1 for in_sel = 0; a third push with in_sel = 1 is not accepted.
- Simultaneous push/pop with wrap: channel 3 holds 0xA; each cycle push 0xB, 0xC, 0xD, 0xE while out_ready[3] = 1 -> out_3 shows 0xA, 0xB, 0xC, 0xD, 0xE in order, count stays 1, pointers wrap.
- Parallel drain: load one word into each channel (0x0, 0x1, 0x2, 0x3), then set out_ready = 1111 for 1 cycle -> all four pop together, out_valid = 0000.
- Reset mid-operation: channels 0 and 2 full, assert rst for 1 cycle during an in_valid push -> push not accepted, out_valid = 0000 after the edge, subsequent push to channel 0 delivers only the new word.

Source files
------------

// File: rtl/demux_1_4_buffered.sv
// 1:4 stream demultiplexer. Each output channel has its own FIFO and valid/ready handshake,
// so a stalled consumer blocks only its own channel.
module demux_1_4_buffered #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_0,
    output logic [N-1:0] out_1,
    output logic [N-1:0] out_2,
    output logic [N-1:0] out_3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [N-1:0]    storage [4][DEPTH];
    logic [PtrW-1:0] wr_ptr  [4];
    logic [PtrW-1:0] rd_ptr  [4];
    logic [CntW-1:0] count   [4];

    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        for (int k = 0; k < 4; k++) begin
            full[k]  = (count[k] == CntW'(DEPTH));
            empty[k] = (count[k] == '0);
        end
        // No pass-through when full: a same-cycle pop does not free the slot for this push.
        in_ready = !full[in_sel] && !rst;
        for (int k = 0; k < 4; k++) begin
            push[k] = in_valid && in_ready && (in_sel == 2'(k));
            pop[k]  = !empty[k] && out_ready[k];
        end
    end

    assign out_valid = ~empty;
    assign out_0     = storage[0][rd_ptr[0]];
    assign out_1     = storage[1][rd_ptr[1]];
    assign out_2     = storage[2][rd_ptr[2]];
    assign out_3     = storage[3][rd_ptr[3]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    storage[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    storage[k][wr_ptr[k]] <= in_data;
                    wr_ptr[k]             <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + 1'b1;
                    2'b01:   count[k] <= count[k] - 1'b1;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_1_4_buffered.sv
// Directed self-checking bench for demux_1_4_buffered (N = 32, DEPTH = 2).
module tb_demux_1_4_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_0, out_1, out_2, out_3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    demux_1_4_buffered #(.N(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_0     (out_0),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] sel, input logic [31:0] data);
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        step();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst got %b want 0", in_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got %b want 0000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({out_0, out_1, out_2, out_3} !== 128'h0)
            $display("FAIL reset_outs got %h %h %h %h want 0", out_0, out_1, out_2, out_3);
        else pass_cnt++;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL reset_in_ready sel=%0d got %b want 1", s, in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_route();
        in_sel = 2'd2;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL route_in_ready got %b want 1", in_ready);
        else pass_cnt++;
        push_word(2'd2, 32'hDEADBEEF);
        total_cnt++;
        if (out_valid !== 4'b0100) $display("FAIL route_out_valid got %b want 0100", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_2 !== 32'hDEADBEEF) $display("FAIL route_out_2 got %h want deadbeef", out_2);
        else pass_cnt++;
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL route_pop got %b want 0000", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_fill_stall();
        push_word(2'd1, 32'h11);
        push_word(2'd1, 32'h22);
        in_sel   = 2'd1;
        in_data  = 32'h33;
        in_valid = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fill_in_ready_sel1 got %b want 0", in_ready);
        else pass_cnt++;
        in_sel = 2'd0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL fill_in_ready_sel0 got %b want 1", in_ready);
        else pass_cnt++;
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0010 || out_1 !== 32'h11)
            $display("FAIL fill_head got valid=%b data=%h want 0010 11", out_valid, out_1);
        else pass_cnt++;
        out_ready = 4'b0010;
        step();
        total_cnt++;
        if (out_1 !== 32'h22) $display("FAIL fill_second got %h want 22", out_1);
        else pass_cnt++;
        step();
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL fill_third_dropped got %b want 0000", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_push_pop_wrap();
        logic [31:0] vals [5];
        vals = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        push_word(2'd3, 32'hA);
        for (int i = 1; i < 5; i++) begin
            in_sel    = 2'd3;
            in_data   = vals[i];
            in_valid  = 1'b1;
            out_ready = 4'b1000;
            #1;
            total_cnt++;
            if (out_3 !== vals[i-1] || out_valid !== 4'b1000 || in_ready !== 1'b1)
                $display("FAIL wrap_head%0d got data=%h valid=%b rdy=%b want %h 1000 1",
                         i, out_3, out_valid, in_ready, vals[i-1]);
            else pass_cnt++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_3 !== 32'hE || out_valid !== 4'b1000)
            $display("FAIL wrap_tail got data=%h valid=%b want e 1000", out_3, out_valid);
        else pass_cnt++;
        out_ready = 4'b1000;
        step();
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL wrap_drain got %b want 0000", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_parallel_drain();
        for (int k = 0; k < 4; k++) push_word(2'(k), 32'(k));
        total_cnt++;
        if (out_valid !== 4'b1111) $display("FAIL drain_loaded got %b want 1111", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_0 !== 32'h0 || out_1 !== 32'h1 || out_2 !== 32'h2 || out_3 !== 32'h3)
            $display("FAIL drain_data got %h %h %h %h want 0 1 2 3", out_0, out_1, out_2, out_3);
        else pass_cnt++;
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL drain_all got %b want 0000", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        push_word(2'd0, 32'h1);
        push_word(2'd0, 32'h2);
        push_word(2'd2, 32'h3);
        push_word(2'd2, 32'h4);
        total_cnt++;
        if (out_valid !== 4'b0101) $display("FAIL rstmid_loaded got %b want 0101", out_valid);
        else pass_cnt++;
        in_sel   = 2'd1;
        in_data  = 32'h55;
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready got %b want 0", in_ready);
        else pass_cnt++;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL rstmid_out_valid got %b want 0000", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_0 !== 32'h0 || out_2 !== 32'h0)
            $display("FAIL rstmid_storage got %h %h want 0 0", out_0, out_2);
        else pass_cnt++;
        push_word(2'd0, 32'h77);
        total_cnt++;
        if (out_valid !== 4'b0001 || out_0 !== 32'h77)
            $display("FAIL rstmid_new got valid=%b data=%h want 0001 77", out_valid, out_0);
        else pass_cnt++;
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        #1;
        total_cnt++;
        if (out_valid !== 4'b0000) $display("FAIL rstmid_only_new got %b want 0000", out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_fill_stall();
        test_push_pop_wrap();
        test_parallel_drain();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
